// File: rtl/adder32_sum_accumulator.sv
// Frame accumulator for adder sums: adds frame_len accepted sums into a wide
// register, then holds the frame total on a valid/ready output until taken.
//
// state | meaning
// ACCUM | accepting sums, building the frame total
// DONE  | frame total presented on acc_o, waiting for acc_ready_i
module adder32_sum_accumulator #(
    parameter int nb_bits   = 32,
    parameter int acc_bits  = 40,
    parameter int frame_len = 4,
    localparam int CW       = $clog2(frame_len + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [nb_bits:0]    sum_i,
    input  logic                sum_valid_i,
    output logic                sum_ready_o,
    input  logic                clear_i,
    output logic [acc_bits-1:0] acc_o,
    output logic                acc_valid_o,
    input  logic                acc_ready_i,
    output logic                ovf_o,
    output logic [CW-1:0]       count_o
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [acc_bits-1:0] acc_q, acc_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d;

    logic                in_hs;
    logic [acc_bits:0]   acc_sum;

    // One extra bit captures the carry out of the accumulator's top bit.
    assign acc_sum = {1'b0, acc_q} + {{(acc_bits - nb_bits){1'b0}}, sum_i};
    assign in_hs   = sum_valid_i & sum_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            state_d = ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_hs) begin
                        acc_d   = acc_sum[acc_bits-1:0];
                        count_d = count_q + CW'(1);
                        if (acc_sum[acc_bits]) begin
                            ovf_d = 1'b1;
                        end
                        if (count_q == CW'(frame_len - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    // No bypass into the next frame: restart happens on the following edge.
                    if (acc_ready_i) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_comb begin
        sum_ready_o = (state_q == ACCUM) && !clear_i;
        acc_valid_o = (state_q == DONE);
    end

    assign acc_o   = acc_q;
    assign ovf_o   = ovf_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_adder32_sum_accumulator.sv
// Directed bench for adder32_sum_accumulator: default, narrow-accumulator
// and single-sum-frame instances driven from one initial block.
module tb_adder32_sum_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // default instance
    logic [32:0] d_sum = '0;
    logic        d_sv = 1'b0, d_clr = 1'b0, d_ar = 1'b0;
    logic        d_sr, d_av, d_ovf;
    logic [39:0] d_acc;
    logic [2:0]  d_cnt;

    // acc_bits=34 instance
    logic [32:0] o_sum = '0;
    logic        o_sv = 1'b0, o_clr = 1'b0, o_ar = 1'b0;
    logic        o_sr, o_av, o_ovf;
    logic [33:0] o_acc;
    logic [2:0]  o_cnt;

    // frame_len=1 instance
    logic [32:0] f_sum = '0;
    logic        f_sv = 1'b0, f_clr = 1'b0, f_ar = 1'b0;
    logic        f_sr, f_av, f_ovf;
    logic [39:0] f_acc;
    logic [0:0]  f_cnt;

    adder32_sum_accumulator u_def (
        .clk_i(clk), .rst_ni(rst_n), .sum_i(d_sum), .sum_valid_i(d_sv),
        .sum_ready_o(d_sr), .clear_i(d_clr), .acc_o(d_acc), .acc_valid_o(d_av),
        .acc_ready_i(d_ar), .ovf_o(d_ovf), .count_o(d_cnt)
    );

    adder32_sum_accumulator #(.nb_bits(32), .acc_bits(34), .frame_len(4)) u_ovf (
        .clk_i(clk), .rst_ni(rst_n), .sum_i(o_sum), .sum_valid_i(o_sv),
        .sum_ready_o(o_sr), .clear_i(o_clr), .acc_o(o_acc), .acc_valid_o(o_av),
        .acc_ready_i(o_ar), .ovf_o(o_ovf), .count_o(o_cnt)
    );

    adder32_sum_accumulator #(.nb_bits(32), .acc_bits(40), .frame_len(1)) u_f1 (
        .clk_i(clk), .rst_ni(rst_n), .sum_i(f_sum), .sum_valid_i(f_sv),
        .sum_ready_o(f_sr), .clear_i(f_clr), .acc_o(f_acc), .acc_valid_o(f_av),
        .acc_ready_i(f_ar), .ovf_o(f_ovf), .count_o(f_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tests++; if (d_acc !== 40'h0) begin fails++; $display("FAIL reset_acc: got %h expected 0", d_acc); end
        tests++; if (d_cnt !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", d_cnt); end
        tests++; if (d_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", d_ovf); end
        tests++; if (d_av !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", d_av); end
        tests++; if (d_sr !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", d_sr); end
        tests++; if (o_av !== 1'b0 || f_av !== 1'b0) begin fails++; $display("FAIL reset_valid_others: got %b %b expected 0 0", o_av, f_av); end
    endtask

    task automatic test_basic();
        d_sum = 33'h1FFFFFFFE;
        d_sv = 1'b1;
        d_ar = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            tests++; if (d_sr !== 1'b1) begin fails++; $display("FAIL basic_ready[%0d]: got %b expected 1", i, d_sr); end
            tick();
            tests++; if (d_cnt !== 3'(i)) begin fails++; $display("FAIL basic_count[%0d]: got %0d expected %0d", i, d_cnt, i); end
            tests++; if (d_av !== (i == 4)) begin fails++; $display("FAIL basic_valid[%0d]: got %b expected %b", i, d_av, (i == 4)); end
        end
        tests++; if (d_acc !== 40'h7FFFFFFF8) begin fails++; $display("FAIL basic_acc: got %h expected 7fffffff8", d_acc); end
        tests++; if (d_ovf !== 1'b0) begin fails++; $display("FAIL basic_ovf: got %b expected 0", d_ovf); end
        d_sv = 1'b0;
        #1;
        tests++; if (d_sr !== 1'b0) begin fails++; $display("FAIL basic_done_ready: got %b expected 0", d_sr); end
        tick();
        tests++; if (d_av !== 1'b0) begin fails++; $display("FAIL basic_accepted_valid: got %b expected 0", d_av); end
        tests++; if (d_cnt !== 3'd0 || d_acc !== 40'h0) begin fails++; $display("FAIL basic_restart: got count %0d acc %h expected 0 0", d_cnt, d_acc); end
        tests++; if (d_sr !== 1'b1) begin fails++; $display("FAIL basic_ready_after: got %b expected 1", d_sr); end
        d_sum = 33'd3;
        d_sv = 1'b1;
        tick();
        tests++; if (d_cnt !== 3'd1 || d_acc !== 40'd3) begin fails++; $display("FAIL basic_next_frame: got count %0d acc %h expected 1 3", d_cnt, d_acc); end
        d_sv = 1'b0;
        d_clr = 1'b1;
        tick();
        d_clr = 1'b0;
    endtask

    task automatic test_overflow();
        o_sum = 33'h1FFFFFFFE;
        o_sv = 1'b1;
        o_ar = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests++; if (o_ovf !== (i >= 3)) begin fails++; $display("FAIL ovf_flag[%0d]: got %b expected %b", i, o_ovf, (i >= 3)); end
        end
        tests++; if (o_av !== 1'b1) begin fails++; $display("FAIL ovf_valid: got %b expected 1", o_av); end
        tests++; if (o_acc !== 34'h3FFFFFFF8) begin fails++; $display("FAIL ovf_acc: got %h expected 3fffffff8", o_acc); end
        o_sum = 33'd1;
        tick();
        tests++; if (o_ovf !== 1'b0 || o_av !== 1'b0) begin fails++; $display("FAIL ovf_cleared: got ovf %b valid %b expected 0 0", o_ovf, o_av); end
        tick();
        tests++; if (o_acc !== 34'd1 || o_ovf !== 1'b0) begin fails++; $display("FAIL ovf_next_frame: got acc %h ovf %b expected 1 0", o_acc, o_ovf); end
        o_sv = 1'b0;
        o_clr = 1'b1;
        tick();
        o_clr = 1'b0;
    endtask

    task automatic test_backpressure();
        d_sum = 33'h5F5E0FF;
        d_ar = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            d_sv = 1'b1;
            tick();
            tests++; if (d_cnt !== 3'(i)) begin fails++; $display("FAIL bp_count[%0d]: got %0d expected %0d", i, d_cnt, i); end
            if (i < 4) begin
                d_sv = 1'b0;
                tick();
                tests++; if (d_cnt !== 3'(i)) begin fails++; $display("FAIL bp_gap_hold[%0d]: got %0d expected %0d", i, d_cnt, i); end
            end
        end
        // Keep offering a sum while DONE; it must not be taken.
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++; if (d_sr !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d]: got %b expected 0", c, d_sr); end
            tests++; if (d_av !== 1'b1 || d_acc !== 40'h17D783FC || d_cnt !== 3'd4) begin fails++; $display("FAIL bp_hold[%0d]: got valid %b acc %h count %0d expected 1 17d783fc 4", c, d_av, d_acc, d_cnt); end
            tick();
        end
        d_sv = 1'b0;
        d_ar = 1'b1;
        #1;
        tests++; if (d_sr !== 1'b0) begin fails++; $display("FAIL bp_ready_same_cycle: got %b expected 0", d_sr); end
        tick();
        tests++; if (d_sr !== 1'b1 || d_av !== 1'b0) begin fails++; $display("FAIL bp_release: got ready %b valid %b expected 1 0", d_sr, d_av); end
    endtask

    task automatic test_mid_clear();
        d_ar = 1'b1;
        d_sum = 33'd5;
        d_sv = 1'b1;
        tick();
        tick();
        tests++; if (d_cnt !== 3'd2 || d_acc !== 40'd10) begin fails++; $display("FAIL clr_pre: got count %0d acc %h expected 2 a", d_cnt, d_acc); end
        d_sum = 33'd7;
        d_clr = 1'b1;
        #1;
        tests++; if (d_sr !== 1'b0) begin fails++; $display("FAIL clr_ready: got %b expected 0", d_sr); end
        tick();
        d_clr = 1'b0;
        d_sv = 1'b0;
        tests++; if (d_cnt !== 3'd0 || d_acc !== 40'd0) begin fails++; $display("FAIL clr_zero: got count %0d acc %h expected 0 0", d_cnt, d_acc); end
        d_sv = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            d_sum = 33'(i);
            tick();
        end
        d_sv = 1'b0;
        tests++; if (d_av !== 1'b1 || d_acc !== 40'd10) begin fails++; $display("FAIL clr_next_frame: got valid %b acc %h expected 1 a", d_av, d_acc); end
        tick();
    endtask

    task automatic test_reset_and_done_clear();
        d_ar = 1'b0;
        d_sum = 33'd9;
        d_sv = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        d_sv = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tests++; if (d_acc !== 40'h0 || d_cnt !== 3'd0 || d_ovf !== 1'b0 || d_av !== 1'b0) begin fails++; $display("FAIL rst_mid: got acc %h count %0d ovf %b valid %b expected all 0", d_acc, d_cnt, d_ovf, d_av); end
        tests++; if (d_sr !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b expected 1", d_sr); end
        d_sum = 33'd1;
        d_sv = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        d_sv = 1'b0;
        tests++; if (d_av !== 1'b1 || d_acc !== 40'd4) begin fails++; $display("FAIL done_pre: got valid %b acc %h expected 1 4", d_av, d_acc); end
        d_clr = 1'b1;
        tick();
        d_clr = 1'b0;
        tests++; if (d_av !== 1'b0 || d_acc !== 40'd0 || d_cnt !== 3'd0) begin fails++; $display("FAIL done_clear: got valid %b acc %h count %0d expected 0 0 0", d_av, d_acc, d_cnt); end
        tick();
        tick();
        tests++; if (d_av !== 1'b0 || d_sr !== 1'b1) begin fails++; $display("FAIL done_clear_idle: got valid %b ready %b expected 0 1", d_av, d_sr); end
    endtask

    task automatic test_frame_len1();
        logic [32:0] vals [3];
        vals[0] = 33'h0;
        vals[1] = 33'h1FFFFFFFF;
        vals[2] = 33'h1;
        f_ar = 1'b1;
        f_sv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f_sum = vals[i];
            tick();
            tests++; if (f_av !== 1'b1 || f_acc !== {7'h0, vals[i]} || f_cnt !== 1'b1) begin fails++; $display("FAIL f1_result[%0d]: got valid %b acc %h count %0d expected 1 %h 1", i, f_av, f_acc, f_cnt, vals[i]); end
            tests++; if (f_sr !== 1'b0) begin fails++; $display("FAIL f1_done_ready[%0d]: got %b expected 0", i, f_sr); end
            if (i < 2) f_sum = vals[i+1];
            else f_sv = 1'b0;
            tick();
            tests++; if (f_av !== 1'b0 || f_acc !== 40'h0) begin fails++; $display("FAIL f1_bubble[%0d]: got valid %b acc %h expected 0 0", i, f_av, f_acc); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_mid_clear();
        test_reset_and_done_clear();
        test_frame_len1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
